// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues word reads to a 1-cycle IMEM,
// buffers {instr, pc} in a small FIFO for decode. Optional macro: FETCH_BYPASS_EN.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_en,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [31:0]                id_instr,
  output logic [31:0]                id_pc,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int          AW  = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Handshake: an instruction transfers to decode on any clock edge where
  // id_valid && id_ready are both high; id_* hold steady while id_valid && !id_ready.

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   pc_q;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic [AW+1:0] reserved;
  logic          issue;
  logic          push;
  logic          pop;
  logic          not_empty;
  entry_t        head;

  assign count     = wr_ptr - rd_ptr;
  assign not_empty = (count != '0);
  assign head      = mem[rd_ptr[AW-1:0]];
  assign occupancy = count;

  // Slot reservation counts the read in flight and ignores a same-cycle pop,
  // so a returning word always has room.
  assign reserved  = {1'b0, count} + {{(AW+1){1'b0}}, inflight};
  assign issue     = !rst && !redirect && (reserved < (AW+2)'(DEPTH));
  assign imem_en   = issue;
  assign imem_addr = pc_q;

`ifdef FETCH_BYPASS_EN
  logic bypass;

  // Returning word goes straight to decode when the FIFO is empty.
  assign bypass   = !not_empty && inflight && !redirect;
  assign id_valid = not_empty || bypass;
  assign pop      = not_empty && id_ready;
  assign push     = inflight && !redirect && !(bypass && id_ready);

  always_comb begin
    id_instr = NOP;
    id_pc    = 32'h0;
    if (not_empty) begin
      id_instr = head.instr;
      id_pc    = head.pc;
    end else if (bypass) begin
      id_instr = imem_rdata;
      id_pc    = inflight_pc;
    end
  end
`else
  assign id_valid = not_empty;
  assign pop      = not_empty && id_ready;
  assign push     = inflight && !redirect;

  always_comb begin
    id_instr = NOP;
    id_pc    = 32'h0;
    if (not_empty) begin
      id_instr = head.instr;
      id_pc    = head.pc;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (redirect) begin
      // Flush: queued words and the returning read are dropped.
      pc_q     <= redirect_pc & ~32'h3;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc_q        <= pc_q + 32'd4;
        inflight_pc <= pc_q;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (!rst && !redirect && push) begin
      mem[wr_ptr[AW-1:0]] <= '{instr: imem_rdata, pc: inflight_pc};
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && count == (AW+1)'(DEPTH)));

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic, compared each cycle
// against a queue-based model of the fetch stream.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
  localparam int          LAT      = 1;
`else
  localparam int          LAT      = 2;
`endif

  logic        clk;
  logic        rst;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [2:0]  occupancy;

  int n_checks;
  int n_pass;

  // Model state: fetch PC, pending read, and PCs waiting for decode.
  logic [31:0] m_pc;
  logic        m_infl;
  logic [31:0] m_infl_pc;
  logic [31:0] exp_q[$];

  fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .occupancy(occupancy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // IMEM: data one cycle after issue, garbage otherwise.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= imem_addr ^ KEY;
    else         imem_rdata <= $urandom();
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Drive one cycle, compare outputs with the model, then advance the model.
  task automatic step(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
    int          sz;
    logic        byp;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_en;
    logic        old_infl;
    logic [31:0] old_infl_pc;
    @(negedge clk);
    rst = r; redirect = rd; redirect_pc = rpc; id_ready = rdy;
    #1;
    sz = exp_q.size();
`ifdef FETCH_BYPASS_EN
    byp = (sz == 0) && m_infl && !rd;
`else
    byp = 1'b0;
`endif
    e_valid = (sz != 0) || byp;
    e_pc    = (sz != 0) ? exp_q[0] : (byp ? m_infl_pc : 32'h0);
    e_en    = !r && !rd && ((sz + int'(m_infl)) < DEPTH);
    check("id_valid", {31'b0, id_valid}, {31'b0, e_valid});
    check("id_pc", id_pc, e_pc);
    check("id_instr", id_instr, e_valid ? (e_pc ^ KEY) : NOP);
    check("occupancy", {29'b0, occupancy}, sz);
    check("imem_en", {31'b0, imem_en}, {31'b0, e_en});
    check("imem_addr", imem_addr, m_pc);
    if (r) begin
      m_pc = RESET_PC; m_infl = 1'b0; exp_q.delete();
    end else if (rd) begin
      m_pc = rpc & ~32'h3; m_infl = 1'b0; exp_q.delete();
    end else begin
      old_infl    = m_infl;
      old_infl_pc = m_infl_pc;
      if (sz != 0 && rdy) void'(exp_q.pop_front());
      if (old_infl && !(byp && rdy)) exp_q.push_back(old_infl_pc);
      m_infl = e_en;
      if (e_en) begin
        m_infl_pc = m_pc;
        m_pc      = m_pc + 32'd4;
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
    m_pc = RESET_PC; m_infl = 1'b0; m_infl_pc = 32'h0;

    // 1: streaming after reset
    do_reset(2);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      if (i >= LAT) check("t1_stream_pc", id_pc, 32'((i - LAT) * 4));
    end

    // 2: decode stalled, queue fills, then drains in order
    do_reset(2);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    check("t2_full", {29'b0, occupancy}, 32'd4);
    check("t2_no_issue", {31'b0, imem_en}, 32'd0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // 3: flush with 3 queued plus one in flight
    do_reset(2);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h100, 1'b0);
    check("t3_occ_before", {29'b0, occupancy}, 32'd3);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t3_occ_after", {29'b0, occupancy}, 32'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // 4: back-to-back redirects with a fire in the first
    step(1'b0, 1'b1, 32'h40, 1'b1);
    step(1'b0, 1'b1, 32'h80, 1'b1);
    for (int i = 0; i < LAT + 1; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t4_first_pc", id_pc, 32'h80);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // 5: alignment and 32-bit wrap of the fetch PC
    step(1'b0, 1'b1, 32'h103, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t5_align", imem_addr, 32'h100);
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t5_top", imem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t5_wrap", imem_addr, 32'h0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // 6: reset mid-stream
    do_reset(1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check("t6_occ_pre", {29'b0, occupancy}, 32'd3);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t6_valid", {31'b0, id_valid}, 32'd0);
    check("t6_occ", {29'b0, occupancy}, 32'd0);
    check("t6_restart", imem_addr, RESET_PC);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 39) == 0,
           $urandom(),
           $urandom_range(0, 9) < 7);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
